inst_rom_loader: RTL

//  Instruction-memory responder for the core's fetch port (rom_ce/rom_addr -> rom_data).

---
 rtl/inst_rom_loader_pkg.sv | 27 ++
 rtl/inst_rom_loader_packer.sv | 43 ++++
 rtl/inst_rom_loader.sv | 115 +++++++++++
 3 files changed

// File: rtl/inst_rom_loader_pkg.sv
// rtl/inst_rom_loader_pkg.sv - loader state encodings and byte-packing helper
package inst_rom_loader_pkg;

    typedef enum logic [1:0] {
        LD_ST_HOLD = 2'b00,
        LD_ST_LOAD = 2'b01,
        LD_ST_RUN  = 2'b10
    } ld_state_e;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Big-endian word from the bytes already buffered plus the current byte;
    // bytes not yet received are zero-filled at the low end.
    function automatic logic [31:0] pack_word(input logic [23:0] buf_v,
                                              input logic [1:0]  cnt,
                                              input logic [7:0]  byte_v);
        logic [31:0] w;
        case (cnt)
            2'd3:    w = {buf_v[23:0], byte_v};
            2'd2:    w = {buf_v[15:0], byte_v, 8'h00};
            2'd1:    w = {buf_v[7:0], byte_v, 16'h0000};
            default: w = {byte_v, 24'h000000};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/inst_rom_loader_packer.sv
// rtl/inst_rom_loader_packer.sv - ld_word_packer: byte stream to 32-bit words
module ld_word_packer
    import inst_rom_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    input  logic        last_i,
    output logic        word_we_o,
    output logic [31:0] word_data_o
);

    logic [31:0] buf_q, buf_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            buf_d = '0;
            cnt_d = '0;
        end else if (byte_en_i) begin
            buf_d = {buf_q[23:0], byte_i};
            cnt_d = (cnt_q == 2'd3 || last_i) ? 2'd0 : cnt_q + 2'd1;
        end
    end

    assign word_we_o   = byte_en_i && !clear_i && (cnt_q == 2'd3 || last_i);
    assign word_data_o = pack_word(buf_q[23:0], cnt_q, byte_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/inst_rom_loader.sv
// rtl/inst_rom_loader.sv - runtime-loadable instruction ROM holding the core in reset while loading
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [31:0]       rom_addr_i,
    output logic [DATA_W-1:0] rom_data_o,
    input  logic              ld_start_i,
    input  logic              ld_valid_i,
    input  logic [7:0]        ld_byte_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    output logic              ld_busy_o,
    output logic              ld_done_o,
    output logic              ld_err_o,
    output logic              cpu_rst_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    ld_state_e             state_q, state_d;
    logic [DEPTH_LOG2:0]   wptr_q, wptr_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;
    logic                  clear;
    logic                  accept;
    logic                  full;
    logic                  word_we;
    logic [31:0]           word_data;
    logic                  mem_we;
    logic [DATA_W-1:0]     mem [DEPTH];
    logic                  unused_addr_bits;

    assign ld_ready_o = (state_q == LD_ST_LOAD);
    assign ld_busy_o  = (state_q == LD_ST_LOAD);
    assign cpu_rst_o  = (state_q != LD_ST_RUN);
    assign ld_done_o  = done_q;
    assign ld_err_o   = err_q;
    assign accept     = ld_valid_i && ld_ready_o;
    // wptr saturates at DEPTH, so its top bit alone marks the array as full
    assign full       = wptr_q[DEPTH_LOG2];
    assign mem_we     = word_we && !full;

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        err_d   = err_q;
        done_d  = 1'b0;
        clear   = 1'b0;
        case (state_q)
            LD_ST_LOAD: begin
                if (accept) begin
                    if (full) err_d = 1'b1;
                    if (mem_we) wptr_d = wptr_q + 1'b1;
                    if (ld_last_i) begin
                        state_d = LD_ST_RUN;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                if (ld_start_i) begin
                    state_d = LD_ST_LOAD;
                    wptr_d  = '0;
                    err_d   = 1'b0;
                    clear   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LD_ST_HOLD;
            wptr_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    ld_word_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear),
        .byte_en_i   (accept),
        .byte_i      (ld_byte_i),
        .last_i      (ld_last_i),
        .word_we_o   (word_we),
        .word_data_o (word_data)
    );

    // Program image survives reset so a core reset does not force a reload
    always_ff @(posedge clk) begin
        if (mem_we) mem[wptr_q[DEPTH_LOG2-1:0]] <= word_data;
    end

    assign unused_addr_bits = ^rom_addr_i[1:0];

    always_comb begin
        rom_data_o = ZERO_WORD;
        if (rom_ce_i && state_q == LD_ST_RUN && rom_addr_i[31:DEPTH_LOG2+2] == '0)
            rom_data_o = mem[rom_addr_i[DEPTH_LOG2+1:2]];
    end

endmodule
